// File: rtl/lsu_out_pkg.sv
// lsu_out_pkg
// Shared definitions for the LSU output peripheral: register word offsets
// (byte offset >> 2), reset constants, a register-select enum and a decode
// helper used by both the write path and the readback mux.
package lsu_out_pkg;

  // Word offsets inside the 64-byte output region (addr[5:2])
  localparam logic [3:0] LEDR_OFF   = 4'h0;  // byte 0x00
  localparam logic [3:0] LEDG_OFF   = 4'h4;  // byte 0x10
  localparam logic [3:0] HEX_LO_OFF = 4'h8;  // byte 0x20, HEX0..HEX3
  localparam logic [3:0] HEX_HI_OFF = 4'h9;  // byte 0x24, HEX4..HEX7
  localparam logic [3:0] LCD_OFF    = 4'hC;  // byte 0x30

  localparam logic [6:0] HEX_BLANK  = 7'h7F; // all segments off (active-low)
  localparam int         LEDR_W     = 17;
  localparam int         LEDG_W     = 8;
  localparam int         NUM_DIGITS = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_LEDR,
    REG_LEDG,
    REG_HEX_LO,
    REG_HEX_HI,
    REG_LCD
  } reg_sel_e;

  // Map a word offset to the register it selects; anything else is unmapped.
  function automatic reg_sel_e decode_reg(input logic [3:0] word);
    reg_sel_e sel;
    case (word)
      LEDR_OFF:   sel = REG_LEDR;
      LEDG_OFF:   sel = REG_LEDG;
      HEX_LO_OFF: sel = REG_HEX_LO;
      HEX_HI_OFF: sel = REG_HEX_HI;
      LCD_OFF:    sel = REG_LCD;
      default:    sel = REG_NONE;
    endcase
    return sel;
  endfunction

  // Pack four 7-bit digits into a word, one digit per byte, bit 7 of each byte zero.
  function automatic logic [31:0] pack_digits(input logic [6:0] d3, input logic [6:0] d2,
                                               input logic [6:0] d1, input logic [6:0] d0);
    return {1'b0, d3, 1'b0, d2, 1'b0, d1, 1'b0, d0};
  endfunction

endpackage

// File: rtl/lsu_out_scan.sv
// lsu_out_scan
// Time-multiplexed 7-segment scan driver for boards whose digits share one
// segment bus. Each digit is shown for SCAN_DIV clock cycles in turn.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   hex_bus  flattened digits, digit i in bits [7i+6:7i]
//   seg_o    registered segment bus, active-low
//   an_o     registered digit enables, active-low one-hot
module lsu_out_scan
  import lsu_out_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [55:0] hex_bus,
  output logic [6:0]  seg_o,
  output logic [7:0]  an_o
);

  localparam int unsigned         DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [2:0]       idx_next;
  logic             wrap;
  logic [6:0]       digit [NUM_DIGITS];

  // Unflatten the digit bus so the selected digit can be picked by index.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit[i] = hex_bus[7*i +: 7];
    end
  end

  // idx is 3 bits wide, so 7 -> 0 wraps naturally.
  always_comb begin
    wrap     = (div == DIV_LAST);
    idx_next = idx + 3'd1;
  end

  // Outputs are reloaded only on the wrap edge, sampling the digit that is
  // about to be selected; between wraps seg_o/an_o hold steady.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div   <= '0;
      idx   <= '0;
      an_o  <= 8'hFE;
      seg_o <= HEX_BLANK;
    end else if (wrap) begin
      div   <= '0;
      idx   <= idx_next;
      an_o  <= ~(8'b1 << idx_next);
      seg_o <= digit[idx_next];
    end else begin
      div   <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/lsu_out_periph.sv
// lsu_out_periph
// Memory-mapped output peripheral on the LSU store path. Byte-masked stores
// update LED, 7-segment and LCD registers; the addressed word is readable
// combinationally in the same cycle. A scan driver serves shared-segment displays.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   addr_i[5:0]           byte offset (bits [1:0] ignored)
//   wren_i, bmask_i[3:0]  store strobe and byte-lane enables
//   wdata_i[31:0]         lane-aligned store data
//   rdata_o[31:0]         readback of the addressed word (0 when unmapped)
//   ledr_o, ledg_o        red / green LEDs
//   hex0_o..hex7_o        direct 7-segment digits, active-low
//   lcd_o                 LCD control/data word
//   seg_o, an_o           scanned segment bus and digit enables, active-low
module lsu_out_periph
  import lsu_out_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [5:0]        addr_i,
  input  logic              wren_i,
  input  logic [3:0]        bmask_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic [LEDR_W-1:0] ledr_o,
  output logic [LEDG_W-1:0] ledg_o,
  output logic [6:0]        hex0_o,
  output logic [6:0]        hex1_o,
  output logic [6:0]        hex2_o,
  output logic [6:0]        hex3_o,
  output logic [6:0]        hex4_o,
  output logic [6:0]        hex5_o,
  output logic [6:0]        hex6_o,
  output logic [6:0]        hex7_o,
  output logic [31:0]       lcd_o,
  output logic [6:0]        seg_o,
  output logic [7:0]        an_o
);

  logic [LEDR_W-1:0] ledr_q;
  logic [LEDG_W-1:0] ledg_q;
  logic [6:0]        hex_q [NUM_DIGITS];
  logic [31:0]       lcd_q;
  reg_sel_e          sel;
  logic [55:0]       hex_bus;
  logic              unused_addr_lsbs;

  // Stores are word-aligned; the byte-within-word bits carry no information.
  assign unused_addr_lsbs = ^addr_i[1:0];

  always_comb begin
    sel = decode_reg(addr_i[5:2]);
  end

  // Byte-lane write path. Only implemented bits of each enabled lane are
  // stored: LEDR lane 2 keeps just bit 16, and bit 7 of each HEX lane is
  // dropped. Unmapped offsets and an all-zero mask fall through untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      for (int n = 0; n < NUM_DIGITS; n++) begin
        hex_q[n] <= HEX_BLANK;
      end
    end else if (wren_i) begin
      case (sel)
        REG_LEDR: begin
          if (bmask_i[0]) ledr_q[7:0]  <= wdata_i[7:0];
          if (bmask_i[1]) ledr_q[15:8] <= wdata_i[15:8];
          if (bmask_i[2]) ledr_q[16]   <= wdata_i[16];
        end
        REG_LEDG: begin
          if (bmask_i[0]) ledg_q <= wdata_i[7:0];
        end
        REG_HEX_LO: begin
          for (int n = 0; n < 4; n++) begin
            if (bmask_i[n]) hex_q[n] <= wdata_i[8*n +: 7];
          end
        end
        REG_HEX_HI: begin
          for (int n = 0; n < 4; n++) begin
            if (bmask_i[n]) hex_q[n+4] <= wdata_i[8*n +: 7];
          end
        end
        REG_LCD: begin
          for (int n = 0; n < 4; n++) begin
            if (bmask_i[n]) lcd_q[8*n +: 8] <= wdata_i[8*n +: 8];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Readback reflects register state only, so a same-cycle store shows the
  // old value until the edge.
  always_comb begin
    rdata_o = '0;
    case (sel)
      REG_LEDR:   rdata_o = 32'(ledr_q);
      REG_LEDG:   rdata_o = 32'(ledg_q);
      REG_HEX_LO: rdata_o = pack_digits(hex_q[3], hex_q[2], hex_q[1], hex_q[0]);
      REG_HEX_HI: rdata_o = pack_digits(hex_q[7], hex_q[6], hex_q[5], hex_q[4]);
      REG_LCD:    rdata_o = lcd_q;
      default:    rdata_o = '0;
    endcase
  end

  assign ledr_o = ledr_q;
  assign ledg_o = ledg_q;
  assign lcd_o  = lcd_q;
  assign hex0_o = hex_q[0];
  assign hex1_o = hex_q[1];
  assign hex2_o = hex_q[2];
  assign hex3_o = hex_q[3];
  assign hex4_o = hex_q[4];
  assign hex5_o = hex_q[5];
  assign hex6_o = hex_q[6];
  assign hex7_o = hex_q[7];

  assign hex_bus = {hex_q[7], hex_q[6], hex_q[5], hex_q[4],
                    hex_q[3], hex_q[2], hex_q[1], hex_q[0]};

  lsu_out_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .hex_bus (hex_bus),
    .seg_o   (seg_o),
    .an_o    (an_o)
  );

endmodule

// File: tb/tb_lsu_out_periph.sv
// tb_lsu_out_periph
// Scoreboard bench for lsu_out_periph. The stimulus process drives stores and
// pushes expected output values tagged with the cycle they are due; a monitor
// on the falling edge pops and compares every entry that falls due.
module tb_lsu_out_periph;

  localparam int S_RD   = 0;
  localparam int S_LEDR = 1;
  localparam int S_LEDG = 2;
  localparam int S_HEX0 = 3;  // S_HEX0 + n selects hex<n>_o
  localparam int S_LCD  = 11;
  localparam int S_SEG  = 12;
  localparam int S_AN   = 13;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] value;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  addr;
  logic        wren;
  logic [3:0]  bmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [16:0] ledr;
  logic [7:0]  ledg;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [31:0] lcd;
  logic [6:0]  seg;
  logic [7:0]  an;

  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;
  exp_t sb [$];

  lsu_out_periph #(.SCAN_DIV(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .addr_i  (addr),
    .wren_i  (wren),
    .bmask_i (bmask),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .ledr_o  (ledr),
    .ledg_o  (ledg),
    .hex0_o  (hex0),
    .hex1_o  (hex1),
    .hex2_o  (hex2),
    .hex3_o  (hex3),
    .hex4_o  (hex4),
    .hex5_o  (hex5),
    .hex6_o  (hex6),
    .hex7_o  (hex7),
    .lcd_o   (lcd),
    .seg_o   (seg),
    .an_o    (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_RD:       return rdata;
      S_LEDR:     return 32'(ledr);
      S_LEDG:     return 32'(ledg);
      S_HEX0 + 0: return 32'(hex0);
      S_HEX0 + 1: return 32'(hex1);
      S_HEX0 + 2: return 32'(hex2);
      S_HEX0 + 3: return 32'(hex3);
      S_HEX0 + 4: return 32'(hex4);
      S_HEX0 + 5: return 32'(hex5);
      S_HEX0 + 6: return 32'(hex6);
      S_HEX0 + 7: return 32'(hex7);
      S_LCD:      return lcd;
      S_SEG:      return 32'(seg);
      S_AN:       return 32'(an);
      default:    return 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic pushExpect(input int due, input int sel, input logic [31:0] value, input string name);
    exp_t e;
    e.due   = due;
    e.sel   = sel;
    e.value = value;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] got;
    got = actual(e.sel);
    checks++;
    if (got !== e.value) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %h expected %h", e.name, cycle, got, e.value);
    end
  endtask

  // Compare every expectation due this cycle; anything overdue is a miss.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cycle) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end else if (sb[i].due < cycle) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].due);
        sb.delete(i);
      end
    end
  end

  // One store cycle; inputs change just after the rising edge.
  task automatic applyStimulus(input logic [5:0] a, input logic we, input logic [3:0] bm, input logic [31:0] wd);
    @(posedge clk);
    #1;
    addr  = a;
    wren  = we;
    bmask = bm;
    wdata = wd;
  endtask

  task automatic readIdle(input logic [5:0] a);
    applyStimulus(a, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = 6'h20;
    wren  = 1'b0;
    bmask = 4'h0;
    wdata = 32'h0;

    // Reset state, sampled while reset is held
    pushExpect(1, S_RD,   32'h7F7F7F7F, "reset_rd_hex_lo");
    pushExpect(1, S_LEDR, 32'h0,        "reset_ledr");
    pushExpect(1, S_LEDG, 32'h0,        "reset_ledg");
    pushExpect(1, S_LCD,  32'h0,        "reset_lcd");
    pushExpect(1, S_AN,   32'hFE,       "reset_an");
    pushExpect(1, S_SEG,  32'h7F,       "reset_seg");
    for (int n = 0; n < 8; n++) pushExpect(1, S_HEX0 + n, 32'h7F, $sformatf("reset_hex%0d", n));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // LEDR word store and lane-2 single-bit store
    applyStimulus(6'h00, 1'b1, 4'hF, 32'hFFFFFFFF);
    pushExpect(cycle,     S_RD,   32'h0,        "ledr_old_read");
    pushExpect(cycle + 1, S_LEDR, 32'h0001FFFF, "ledr_word");
    readIdle(6'h00);
    pushExpect(cycle, S_RD, 32'h0001FFFF, "ledr_readback");
    applyStimulus(6'h00, 1'b1, 4'b0100, 32'h0);
    pushExpect(cycle + 1, S_LEDR, 32'h0000FFFF, "ledr_lane2");

    // HEX byte stores
    applyStimulus(6'h24, 1'b1, 4'b0010, 32'h00004000);
    pushExpect(cycle + 1, S_HEX0 + 5, 32'h40, "hex5_lane1");
    pushExpect(cycle + 1, S_HEX0 + 4, 32'h7F, "hex4_untouched");
    pushExpect(cycle + 1, S_HEX0 + 6, 32'h7F, "hex6_untouched");
    pushExpect(cycle + 1, S_HEX0 + 7, 32'h7F, "hex7_untouched");
    applyStimulus(6'h26, 1'b1, 4'b0100, 32'h00120000);
    pushExpect(cycle + 1, S_HEX0 + 6, 32'h12, "hex6_unaligned_addr");
    pushExpect(cycle + 1, S_HEX0 + 5, 32'h40, "hex5_kept");
    readIdle(6'h24);
    pushExpect(cycle, S_RD, 32'h7F12407F, "hex_hi_readback");

    // Back-to-back LCD stores, last writer wins per lane
    applyStimulus(6'h30, 1'b1, 4'hF, 32'h11223344);
    pushExpect(cycle + 1, S_LCD, 32'h11223344, "lcd_word");
    applyStimulus(6'h30, 1'b1, 4'b1010, 32'hAABBCCDD);
    pushExpect(cycle + 1, S_LCD, 32'hAA22CC44, "lcd_lane_merge");

    // Stores that must change nothing
    applyStimulus(6'h3C, 1'b1, 4'hF, 32'hFFFFFFFF);
    pushExpect(cycle, S_RD, 32'h0, "unmapped_read_during_store");
    applyStimulus(6'h30, 1'b1, 4'h0, 32'hDEADBEEF);
    pushExpect(cycle, S_RD, 32'hAA22CC44, "lcd_read_zero_mask");
    readIdle(6'h30);
    pushExpect(cycle, S_RD,       32'hAA22CC44, "lcd_after_zero_mask_rd");
    pushExpect(cycle, S_LCD,      32'hAA22CC44, "lcd_after_zero_mask");
    pushExpect(cycle, S_LEDR,     32'h0000FFFF, "ledr_after_unmapped");
    pushExpect(cycle, S_LEDG,     32'h0,        "ledg_after_unmapped");
    pushExpect(cycle, S_HEX0 + 5, 32'h40,       "hex5_after_unmapped");
    readIdle(6'h3C);
    pushExpect(cycle, S_RD, 32'h0, "unmapped_readback");

    // Same-cycle read/write of LEDG
    applyStimulus(6'h10, 1'b1, 4'h1, 32'h0000005A);
    pushExpect(cycle, S_RD, 32'h0, "ledg_old_during_write");
    readIdle(6'h10);
    pushExpect(cycle, S_RD,   32'h5A, "ledg_new_readback");
    pushExpect(cycle, S_LEDG, 32'h5A, "ledg_new");
    applyStimulus(6'h10, 1'b1, 4'b0010, 32'h0000FF00);
    readIdle(6'h10);
    pushExpect(cycle, S_RD, 32'h5A, "ledg_upper_lane_ignored");

    // Scanner: restart via reset, then load all eight digits right away
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    wren  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    addr  = 6'h20;
    wren  = 1'b1;
    bmask = 4'hF;
    wdata = 32'hB0A4F9C0;  // hex3..0 = 30,24,79,40; bit 7 of each lane not stored
    c0    = cycle;
    pushExpect(c0, S_RD,   32'h7F7F7F7F, "hex_lo_blank_after_reset");
    pushExpect(c0, S_LEDR, 32'h0,        "ledr_cleared_by_reset");
    pushExpect(c0, S_LCD,  32'h0,        "lcd_cleared_by_reset");
    begin
      logic [7:0] an_exp  [9];
      logic [6:0] seg_exp [9];
      an_exp  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
      seg_exp = '{7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h40};
      for (int k = 0; k < 9; k++) begin
        pushExpect(c0 + 4*k,     S_AN,  32'(an_exp[k]),  $sformatf("scan_an_start_%0d", k));
        pushExpect(c0 + 4*k + 3, S_AN,  32'(an_exp[k]),  $sformatf("scan_an_dwell_%0d", k));
        pushExpect(c0 + 4*k,     S_SEG, 32'(seg_exp[k]), $sformatf("scan_seg_%0d", k));
      end
    end
    pushExpect(c0 + 40, S_AN,  32'hFB, "scan_an_second_pass_d2");
    pushExpect(c0 + 40, S_SEG, 32'h24, "scan_seg_second_pass_d2");
    applyStimulus(6'h24, 1'b1, 4'hF, 32'h78021219);
    pushExpect(cycle, S_RD, 32'h7F7F7F7F, "hex_hi_old_during_write");
    readIdle(6'h20);
    pushExpect(cycle, S_RD, 32'h30247940, "hex_lo_readback");
    readIdle(6'h24);
    pushExpect(cycle, S_RD, 32'h78021219, "hex_hi_readback_full");

    // Reset pulse mid-sequence: scanner returns to digit 0 immediately
    while (cycle < c0 + 41) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    pushExpect(cycle, S_AN,       32'hFE, "midscan_reset_an");
    pushExpect(cycle, S_SEG,      32'h7F, "midscan_reset_seg");
    pushExpect(cycle, S_HEX0 + 2, 32'h7F, "midscan_reset_hex2");

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
